mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and access sequencer for the single memory port of the RISC processor. It shares one synchronous-read memory between the CPU core, which issues fetch, load and store traffic, and an I/O/loader master, which preloads programs and reads results. It serialises accesses, applies round-robin fairness, inserts programmable wait states, and returns registered read data with a one-cycle completion pulse. It sits between the processor top level and the memory block, and the CPU stalls on `cpu_req & ~cpu_done`.

## Interface
- `AW`, default 16: address width.
- `DW`, default 16: data width.
- `WAIT_STATES`, default 0: extra cycles the address is held before read data is captured; legal range 0..15.

- `clk`  in  1: single system clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `cpu_req`  in  1: CPU access request; held high until `cpu_done`.
- `cpu_we`  in  1: 1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr`  in  AW: CPU address.
- `cpu_wdata`  in  DW: CPU write data.
- `cpu_gnt`  out  1: CPU owns the memory port (ACC through DONE).
- `cpu_done`  out  1: one-cycle completion pulse for the CPU.
- `cpu_rdata`  out  DW: read data; valid while `cpu_done` = 1.
- `io_req`, `io_we`, `io_addr`, `io_wdata`, `io_gnt`, `io_done`, `io_rdata`: same as the `cpu_*` ports, for the I/O master.
- `mem_addr`  out  AW: memory address.
- `mem_wdata`  out  DW: memory write data.
- `mem_we`  out  1: memory write enable.
- `mem_rdata`  in  DW: memory read data; valid the cycle after the address is sampled.
- `busy`  out  1: state is not IDLE.

## Operation
- FSM states: IDLE, ACC, WAIT, CAP, DONE. `owner` register: 0 = CPU, 1 = IO. `last` register holds the last-served port.
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one request: grant that port.
  - Both requesting: grant the port that is not `last`.
  - On a grant: latch `owner`, addr, we and wdata into the access registers; go to ACC.
- **ACC** (1 cycle)
  - Drive `mem_addr` and `mem_wdata` from the latched values.
  - `mem_we` = latched we, in this cycle only.
  - Next state: WAIT if `WAIT_STATES` > 0, else CAP. Reload the wait counter with `WAIT_STATES`-1.
- **WAIT**
  - Address held, `mem_we` = 0, counter decrements.
  - Go to CAP when the counter reaches 0.
- **CAP** (1 cycle)
  - Address held, `mem_we` = 0.
  - `rdata_q` <= `mem_rdata` at the closing edge. Writes also capture; the value is don't-care for writes.
- **DONE** (1 cycle)
  - The owner's `done` = 1 and its `rdata` = `rdata_q`.
  - `last` <= `owner`; next state IDLE.
  - Requests are ignored in DONE. The requester drops `req` or presents a new request in the cycle after `done`.
- Requester inputs are sampled only in IDLE. Changes to addr, we or wdata after the grant have no effect on the access in flight.
- The non-owner's `gnt` and `done` stay 0 for the whole access; its `rdata` holds its previous value.
- `cpu_rdata` and `io_rdata` are separate registers, updated only in the DONE cycle for their own port.

## Timing
- **Reset values:** state IDLE, `last` = IO (so the CPU wins the first tie). All outputs 0: `mem_addr`, `mem_wdata`, `mem_we`, both `gnt`, both `done`, both `rdata`, `busy`.
- **Latency:** a request sampled high in IDLE at edge E gives ACC in cycle E+1 and `done` in cycle E+3+`WAIT_STATES`. The port returns to IDLE in the following cycle.
- **Back-to-back throughput:** one access per 4+`WAIT_STATES` cycles.
- **Simultaneous requests:** strict alternation while both are held. A lone requester is served every time, regardless of `last`.
- **Reset mid-access:** the access is abandoned at that edge, with no `done` pulse. `mem_we` is 0 from the next cycle and outputs return to their reset values.
- **Write commit:** exactly one `mem_we` cycle per write, never repeated during WAIT or CAP.
- `WAIT_STATES` = 0: the WAIT state is skipped entirely.

## Test plan
- **Reset and idle:** hold `reset` for 2 cycles, then no requests -> all outputs 0, `busy` = 0, and `mem_we` never rises.
- **CPU write then read:** `WAIT_STATES` = 0. CPU writes 16'hBEEF to 16'h0010, then reads 16'h0010.
  - `mem_we` is high for exactly 1 cycle with `mem_addr` = 16'h0010.
  - Each `cpu_done` arrives 3 cycles after its request is sampled.
  - `cpu_rdata` = 16'hBEEF during the read's `cpu_done`.
- **Tie after reset:** both ports raise `req` in the same cycle.
  - CPU is served first, then IO.
  - `io_gnt` stays 0 until the CPU's DONE has passed.
  - Access order is CPU, IO, CPU, IO while both requests are held.
- **Wait states:** `WAIT_STATES` = 3, IO reads 16'h0004 from memory preloaded with 16'h1234 -> `io_done` 6 cycles after the request is sampled, with `io_rdata` = 16'h1234.
- **Reset mid-access:** assert `reset` during WAIT of a CPU read -> no `cpu_done`, all outputs 0 next cycle. A fresh request afterwards completes normally.
- **Input change after grant:** CPU changes `cpu_addr` from 16'h0020 to 16'h0030 during ACC -> memory sees only 16'h0020 and no second access occurs.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read memory port between the CPU
// core and the I/O/loader master. Accesses are serialised and round-robin
// arbitrated. Programmable wait states follow the address phase. Read data
// is returned in a per-port register together with a one-cycle done pulse.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request; req is held until cpu_done
//   cpu_gnt, cpu_done, cpu_rdata   CPU owns the port, completion pulse, read data
//   io_*                           same set of ports for the I/O master
//   mem_addr/wdata/we, mem_rdata   memory port; rdata is valid one cycle after the address
//   busy                           an access is in progress
module mem_port_arbiter #(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  input  logic          io_req,
  input  logic          io_we,
  input  logic [AW-1:0] io_addr,
  input  logic [DW-1:0] io_wdata,
  output logic          io_gnt,
  output logic          io_done,
  output logic [DW-1:0] io_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WAIT_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACC  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_owner;      // 0 = CPU, 1 = IO
  logic          r_last;       // last port served
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_we;
  logic          r_cpu_gnt;
  logic          r_io_gnt;
  logic          r_cpu_done;
  logic          r_io_done;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_io_rdata;
  logic          r_busy;

  logic [2:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_any_req;
  logic          w_pick_io;

  // IO wins when it is the only requester, or on a tie when the CPU was served last
  assign w_any_req = cpu_req | io_req;
  assign w_pick_io = io_req & (~cpu_req | ~r_last);

  // Next-state and wait-counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_state_nxt = S_ACC;
      end
      S_ACC: begin
        if (WAIT_STATES > 0) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = WAIT_LOAD;
        end else begin
          w_state_nxt = S_CAP;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_CAP;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_CAP:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, access latches and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_cpu_gnt   <= 1'b0;
      r_io_gnt    <= 1'b0;
      r_cpu_done  <= 1'b0;
      r_io_done   <= 1'b0;
      r_cpu_rdata <= '0;
      r_io_rdata  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_cpu_done <= (w_state_nxt == S_DONE) & ~r_owner;
      r_io_done  <= (w_state_nxt == S_DONE) &  r_owner;
      // Write strobe lives for the ACC cycle only
      r_mem_we   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner     <= w_pick_io;
            r_mem_addr  <= w_pick_io ? io_addr  : cpu_addr;
            r_mem_wdata <= w_pick_io ? io_wdata : cpu_wdata;
            r_mem_we    <= w_pick_io ? io_we    : cpu_we;
            r_cpu_gnt   <= ~w_pick_io;
            r_io_gnt    <=  w_pick_io;
          end
        end
        S_CAP: begin
          // Capture lands at the edge entering DONE, so rdata is valid with done
          if (r_owner) r_io_rdata  <= mem_rdata;
          else         r_cpu_rdata <= mem_rdata;
        end
        S_DONE: begin
          r_last    <= r_owner;
          r_cpu_gnt <= 1'b0;
          r_io_gnt  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cpu_gnt   = r_cpu_gnt;
  assign cpu_done  = r_cpu_done;
  assign cpu_rdata = r_cpu_rdata;
  assign io_gnt    = r_io_gnt;
  assign io_done   = r_io_done;
  assign io_rdata  = r_io_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A runs with no wait states,
// instance B with three. Each has its own synchronous-read memory model.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;

  logic        a_cpu_req, a_cpu_we, a_cpu_gnt, a_cpu_done;
  logic [15:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
  logic        a_io_req, a_io_we, a_io_gnt, a_io_done;
  logic [15:0] a_io_addr, a_io_wdata, a_io_rdata;
  logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_mem_we, a_busy;

  logic        b_cpu_req, b_cpu_we, b_cpu_gnt, b_cpu_done;
  logic [15:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
  logic        b_io_req, b_io_we, b_io_gnt, b_io_done;
  logic [15:0] b_io_addr, b_io_wdata, b_io_rdata;
  logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_mem_we, b_busy;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];

  int n_checks;
  int n_errors;

  int          a_we_cnt;
  logic [15:0] a_we_addr;
  int          a_acc_cnt;
  bit          a_busy_q;
  int          b_we_cnt;
  int          b_cpu_done_cnt;

  mem_port_arbiter #(.AW(16), .DW(16), .WAIT_STATES(0)) u_dut_a (
    .clk(clk), .reset(reset),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_gnt(a_cpu_gnt), .cpu_done(a_cpu_done), .cpu_rdata(a_cpu_rdata),
    .io_req(a_io_req), .io_we(a_io_we), .io_addr(a_io_addr), .io_wdata(a_io_wdata),
    .io_gnt(a_io_gnt), .io_done(a_io_done), .io_rdata(a_io_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.AW(16), .DW(16), .WAIT_STATES(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_done(b_cpu_done), .cpu_rdata(b_cpu_rdata),
    .io_req(b_io_req), .io_we(b_io_we), .io_addr(b_io_addr), .io_wdata(b_io_wdata),
    .io_gnt(b_io_gnt), .io_done(b_io_done), .io_rdata(b_io_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories: data appears the cycle after the address is sampled
  always @(posedge clk) begin
    if (a_mem_we) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
    a_mem_rdata <= mem_a[a_mem_addr[7:0]];
    if (b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
    b_mem_rdata <= mem_b[b_mem_addr[7:0]];
  end

  // Event monitors sampled mid-cycle
  always @(negedge clk) begin
    if (a_mem_we === 1'b1) begin
      a_we_cnt  <= a_we_cnt + 1;
      a_we_addr <= a_mem_addr;
    end
    if (a_busy === 1'b1 && !a_busy_q) a_acc_cnt <= a_acc_cnt + 1;
    a_busy_q <= (a_busy === 1'b1);
    if (b_mem_we === 1'b1)   b_we_cnt       <= b_we_cnt + 1;
    if (b_cpu_done === 1'b1) b_cpu_done_cnt <= b_cpu_done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel_b, input bit sel_io, input logic req, input logic we,
                       input logic [15:0] addr, input logic [15:0] wd);
    case ({sel_b, sel_io})
      2'b00: begin a_cpu_req = req; a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wd; end
      2'b01: begin a_io_req  = req; a_io_we  = we; a_io_addr  = addr; a_io_wdata  = wd; end
      2'b10: begin b_cpu_req = req; b_cpu_we = we; b_cpu_addr = addr; b_cpu_wdata = wd; end
      default: begin b_io_req = req; b_io_we = we; b_io_addr = addr; b_io_wdata = wd; end
    endcase
  endtask

  function automatic logic done_of(input bit sel_b, input bit sel_io);
    case ({sel_b, sel_io})
      2'b00:   return a_cpu_done;
      2'b01:   return a_io_done;
      2'b10:   return b_cpu_done;
      default: return b_io_done;
    endcase
  endfunction

  function automatic logic [15:0] rdata_of(input bit sel_b, input bit sel_io);
    case ({sel_b, sel_io})
      2'b00:   return a_cpu_rdata;
      2'b01:   return a_io_rdata;
      2'b10:   return b_cpu_rdata;
      default: return b_io_rdata;
    endcase
  endfunction

  // One access; lat counts cycles from the sampling edge to the done pulse
  task automatic access(input bit sel_b, input bit sel_io, input logic we,
                        input logic [15:0] addr, input logic [15:0] wd,
                        output int lat, output logic [15:0] rd);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    rd   = '0;
    drive(sel_b, sel_io, 1'b1, we, addr, wd);
    for (int i = 1; i <= 30 && !seen; i++) begin
      step();
      if (done_of(sel_b, sel_io) === 1'b1) begin
        seen = 1'b1;
        lat  = i;
        rd   = rdata_of(sel_b, sel_io);
      end
    end
    drive(sel_b, sel_io, 1'b0, 1'b0, 16'h0000, 16'h0000);
    if (!seen) chk("access_timeout", 32'(seen), 32'd1);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  function automatic logic [31:0] a_outs();
    return 32'({a_mem_addr, a_mem_wdata} | {a_cpu_rdata, a_io_rdata}) |
           32'({a_mem_we, a_cpu_gnt, a_io_gnt, a_cpu_done, a_io_done, a_busy});
  endfunction

  function automatic logic [31:0] b_outs();
    return 32'({b_mem_addr, b_mem_wdata} | {b_cpu_rdata, b_io_rdata}) |
           32'({b_mem_we, b_cpu_gnt, b_io_gnt, b_cpu_done, b_io_done, b_busy});
  endfunction

  initial begin
    int          lat;
    logic [15:0] rd;
    int          w0;
    int          nd;
    bit          order [4];
    bit          io_early;
    bit          addr_bad;
    int          acc0;

    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Reset and idle
    step();
    step();
    chk("rst_outs_a", a_outs(), 32'd0);
    chk("rst_outs_b", b_outs(), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("idle_outs_a", a_outs(), 32'd0);
    chk("idle_busy_a", 32'(a_busy), 32'd0);
    chk("idle_we_cnt", 32'(a_we_cnt), 32'd0);

    // CPU write then read, no wait states
    w0 = a_we_cnt;
    access(1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, lat, rd);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_we_pulses", 32'(a_we_cnt - w0), 32'd1);
    chk("wr_we_addr", 32'(a_we_addr), 32'h0010);
    access(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, lat, rd);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", 32'(rd), 32'hBEEF);
    chk("rd_no_we", 32'(a_we_cnt - w0), 32'd1);
    chk("rd_idle_busy", 32'(a_busy), 32'd0);

    // Preload for later reads
    access(1'b0, 1'b1, 1'b1, 16'h0040, 16'h5A5A, lat, rd);
    access(1'b0, 1'b0, 1'b1, 16'h0020, 16'h2020, lat, rd);
    access(1'b0, 1'b0, 1'b1, 16'h0030, 16'h3030, lat, rd);
    w0 = b_we_cnt;
    access(1'b1, 1'b0, 1'b1, 16'h0004, 16'h1234, lat, rd);
    chk("b_wr_lat", 32'(lat), 32'd6);
    chk("b_wr_we_pulses", 32'(b_we_cnt - w0), 32'd1);

    // Tie after reset: CPU first, then strict alternation
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000);
    nd       = 0;
    io_early = 1'b0;
    for (int i = 0; i < 60 && nd < 4; i++) begin
      step();
      if (nd == 0 && a_io_gnt === 1'b1) io_early = 1'b1;
      if (a_cpu_done === 1'b1) begin order[nd] = 1'b0; nd++; end
      else if (a_io_done === 1'b1) begin order[nd] = 1'b1; nd++; end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("tie_count", 32'(nd), 32'd4);
    chk("tie_order", {28'd0, order[0], order[1], order[2], order[3]}, 32'b0101);
    chk("tie_io_early", 32'(io_early), 32'd0);
    chk("tie_cpu_rdata", 32'(a_cpu_rdata), 32'hBEEF);
    chk("tie_io_rdata", 32'(a_io_rdata), 32'h5A5A);

    // Lone IO request is served even though IO was last
    access(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, lat, rd);
    chk("lone_io_lat", 32'(lat), 32'd3);
    chk("lone_io_data", 32'(rd), 32'hBEEF);
    chk("lone_cpu_hold", 32'(a_cpu_rdata), 32'hBEEF);

    // Wait states on instance B
    access(1'b1, 1'b1, 1'b0, 16'h0004, 16'h0000, lat, rd);
    chk("ws_lat", 32'(lat), 32'd6);
    chk("ws_data", 32'(rd), 32'h1234);

    // Reset during WAIT of a CPU read
    w0 = b_cpu_done_cnt;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000);
    step();
    step();
    step();
    chk("mid_in_wait_busy", 32'(b_busy), 32'd1);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("mid_outs", b_outs(), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("mid_no_done", 32'(b_cpu_done_cnt - w0), 32'd0);
    chk("mid_outs_later", b_outs(), 32'd0);
    access(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, lat, rd);
    chk("mid_fresh_lat", 32'(lat), 32'd6);
    chk("mid_fresh_data", 32'(rd), 32'h1234);

    // Address change after grant does not affect the access in flight
    acc0     = a_acc_cnt;
    addr_bad = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    step();
    a_cpu_addr = 16'h0030;
    chk("chg_acc_addr", 32'(a_mem_addr), 32'h0020);
    nd = 0;
    for (int i = 0; i < 20 && nd == 0; i++) begin
      step();
      if (a_busy === 1'b1 && a_mem_addr !== 16'h0020) addr_bad = 1'b1;
      if (a_cpu_done === 1'b1) begin
        nd = 1;
        rd = a_cpu_rdata;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 6; i++) step();
    chk("chg_done", 32'(nd), 32'd1);
    chk("chg_addr_held", 32'(addr_bad), 32'd0);
    chk("chg_data", 32'(rd), 32'h2020);
    chk("chg_one_access", 32'(a_acc_cnt - acc0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
